// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for serial_adder_n.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of cycles one operation spends in RUN.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk counter width; at least one bit so NCHUNK=1 still has a counter.
    function automatic int calc_cnt_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

    // Operands must split into whole chunks.
    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && (width % chunk == 0);
    endfunction

endpackage

// File: rtl/serial_adder_n_if.sv
// Request/response handshake bundle for serial_adder_n.
interface serial_adder_n_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder_n_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into
// the top bit so the caller can derive signed overflow.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);
    // Ripple a single carry variable through CHUNK full adders.
    always_comb begin
        logic c;
        c     = ci;
        s     = '0;
        c_msb = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            if (i == CHUNK - 1) c_msb = c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, LSB first.
// Optional macro SERIAL_ADDER_B2B_EN: accept a new request in the same cycle
// the finished result is taken, skipping IDLE.
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_n_if.slave bus
);
    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = calc_cnt_w(NCHUNK);

    if (!width_ok(WIDTH, CHUNK)) begin : g_width_chk
        $error("serial_adder_n: WIDTH must be a multiple of CHUNK");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [CHUNK-1:0]   ch_s;
    logic               ch_co, ch_cmsb;
    logic               in_rdy;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .ci    (carry_q),
        .s     (ch_s),
        .co    (ch_co),
        .c_msb (ch_cmsb)
    );

    // Ready is purely state-derived (plus out_ready when back-to-back is on).
    always_comb begin
`ifdef SERIAL_ADDER_B2B_EN
        in_rdy = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
`else
        in_rdy = (state_q == IDLE);
`endif
    end

    // Next-state and datapath: load operands, shift one chunk per RUN cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            RUN: begin
                // New chunk enters sum from the top so LSB chunk ends at bit 0.
                sum_d   = (sum_q >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = ch_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                    cout_d  = ch_co;
                    ovf_d   = ch_co ^ ch_cmsb;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: ;
        endcase

        // Accept covers IDLE and, with back-to-back, the DONE handoff cycle.
        if (bus.in_valid && in_rdy) begin
            a_d     = bus.a;
            b_d     = bus.sub ? ~bus.b : bus.b;
            carry_d = bus.sub | bus.cin;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    // State registers with asynchronous clear; an aborted op leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n (WIDTH=32, CHUNK=8) with a result scoreboard.
module tb_serial_adder_n;
    localparam int W      = 32;
    localparam int NCHUNK = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    res_t sb_q[$];

    serial_adder_n_if #(.WIDTH(W)) bus ();

    serial_adder_n #(.WIDTH(W), .CHUNK(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 33-bit add; overflow from operand/result sign bits.
    function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                   input logic tcin, input logic tsub);
        res_t r;
        logic [W-1:0] bb;
        logic [W:0]   t;
        bb  = tsub ? ~tb_ : tb_;
        t   = {1'b0, ta} + {1'b0, bb} + (W+1)'(tsub ? 1'b1 : tcin);
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (ta[W-1] == bb[W-1]) && (t[W-1] != ta[W-1]);
        return r;
    endfunction

    // Wait for in_ready, present one request, push its expected result.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tcin, input logic tsub, input res_t exp);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin tick(); n++; end
        chk("in_ready_before_send", 64'(bus.in_ready), 64'd1);
        bus.a = ta; bus.b = tb_; bus.cin = tcin; bus.sub = tsub;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        sb_q.push_back(exp);
    endtask

    // Wait for out_valid, check latency and pop/compare the scoreboard.
    task automatic recv(input string tag, input int exp_lat);
        int   lat;
        res_t e;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin tick(); lat++; end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_sum"},  64'(bus.sum),      64'(e.s));
            chk({tag, "_cout"}, 64'(bus.cout),     64'(e.c));
            chk({tag, "_ovf"},  64'(bus.overflow), 64'(e.o));
        end
    endtask

    task automatic ack(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tcin, input logic tsub, input res_t exp);
        send(ta, tb_, tcin, tsub, exp);
        recv(tag, NCHUNK);
        ack(tag);
    endtask

    initial begin
        logic [W-1:0] ra, rb, hs;
        logic         rc, rs, hc, ho;
        int           rises, t1, t2, n;

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        bus.sub = 1'b0; bus.out_ready = 1'b0;

        // 1: asynchronous reset, asserted between clock edges
        #3 rst = 1'b1;
        #1;
        chk("rst_async_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_async_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_async_sum",       64'(bus.sum),       64'd0);
        chk("rst_async_cout",      64'(bus.cout),      64'd0);
        chk("rst_async_ovf",       64'(bus.overflow),  64'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

        // 2: carry across every chunk, then cin
        op("ffff_plus_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, '{s: 32'h0, c: 1'b1, o: 1'b0});
        op("3_plus_4_c1", 32'd3, 32'd4, 1'b1, 1'b0, '{s: 32'd8, c: 1'b0, o: 1'b0});

        // 3: signed overflow
        op("max_plus_1", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, '{s: 32'h8000_0000, c: 1'b0, o: 1'b1});

        // 4: subtraction, cin ignored
        op("5_minus_7", 32'd5, 32'd7, 1'b1, 1'b1, '{s: 32'hFFFF_FFFE, c: 1'b0, o: 1'b0});
        op("7_minus_5", 32'd7, 32'd5, 1'b0, 1'b1, '{s: 32'd2, c: 1'b1, o: 1'b0});

        // a few random operations against the reference
        for (int i = 0; i < 4; i++) begin
            ra = $urandom(); rb = $urandom(); rc = 1'($urandom()); rs = 1'(i & 1);
            op("rand", ra, rb, rc, rs, model(ra, rb, rc, rs));
        end

        // 5: consumer stall in DONE while the source keeps pushing
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, model(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0));
        recv("stall", NCHUNK);
        hs = bus.sum; hc = bus.cout; ho = bus.overflow;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = $urandom(); bus.b = $urandom(); bus.sub = 1'($urandom());
            tick();
            chk("stall_sum",       64'(bus.sum),       64'(hs));
            chk("stall_cout",      64'(bus.cout),      64'(hc));
            chk("stall_ovf",       64'(bus.overflow),  64'(ho));
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_in_ready",  64'(bus.in_ready),  64'd0);
        end
        bus.in_valid = 1'b0;
        ack("stall");
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) rises++;
        end
        chk("stall_single_handshake", 64'(rises), 64'd0);

        // 6: reset pulse while RUN has counter at 2
        send(32'hDEAD_BEEF, 32'h1, 1'b0, 1'b0, '{s: 32'h0, c: 1'b0, o: 1'b0});
        void'(sb_q.pop_back());   // this op is aborted and must never return
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrun_rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("midrun_rst_sum",       64'(bus.sum),       64'd0);
        tick();
        rst = 1'b0;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid) rises++;
        end
        chk("aborted_no_output", 64'(rises), 64'd0);
        op("after_abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
           '{s: 32'h2345_6789, c: 1'b0, o: 1'b0});

`ifdef SERIAL_ADDER_B2B_EN
        // back-to-back: new request accepted in the result-handshake cycle
        send(32'd10, 32'd20, 1'b0, 1'b0, model(32'd10, 32'd20, 1'b0, 1'b0));
        recv("b2b_first", NCHUNK);
        t1 = cyc;
        bus.a = 32'd100; bus.b = 32'd1; bus.cin = 1'b0; bus.sub = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #0;
        chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        sb_q.push_back(model(32'd100, 32'd1, 1'b0, 1'b1));
        n = 0;
        while (!bus.out_valid && n < 50) begin tick(); n++; end
        t2 = cyc;
        chk("b2b_spacing", 64'(t2 - t1), 64'd5);
        recv("b2b_second", 0);
        ack("b2b_second");
`else
        t1 = 0; t2 = 0; n = 0;
`endif

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
Parametrised multi-cycle adder/subtractor. It generalises the single-bit full adder to WIDTH-bit operands, processing CHUNK bits per clock, LSB chunk first. A registered carry links the chunks. Operands are accepted and results delivered over valid/ready handshakes, so the block sits between a request source and a consumer in the datapath.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 8, bits added per cycle; NCHUNK = WIDTH/CHUNK cycles per operation

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept a request
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; ignored when sub=1
sub  input  1  0: a+b+cin; 1: a-b (computed as a+~b+1)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  final carry out; for sub, 1 = no borrow
overflow  output  1  signed overflow: carry into MSB xor carry out of MSB

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0. Chunk counter=0, carry=0, operand registers=0. An in-flight operation is discarded with no partial output.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - Latch a; latch b, or ~b when sub=1.
  - Carry = sub ? 1 : cin.
  - Counter = 0; go to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle:
  - Add the low CHUNK bits of the A and B shift registers plus carry.
  - Shift the CHUNK-bit result into sum from the top; shift A and B right by CHUNK.
  - Register the carry; increment the counter.
  - On the cycle where counter==NCHUNK-1: capture cout and overflow from the top chunk, then go to DONE.
- DONE: out_valid=1; sum, cout and overflow are held stable. On out_ready go to IDLE (out_valid drops the next cycle). in_valid is ignored while not in IDLE.
- Latency: the accept edge is edge 0. out_valid is high after edge NCHUNK, i.e. 4 cycles for the defaults.
- Throughput: one op per NCHUNK+2 cycles without the optional feature.
- NCHUNK=1 (CHUNK=WIDTH): RUN lasts exactly one cycle; must work.
- Arithmetic is modulo 2^WIDTH. The carry out of the top chunk goes to cout and is never added back.
- Outputs are driven from registers only; no combinational path from inputs to outputs except in_ready (state-derived).

Optional Feature:
SERIAL_ADDER_B2B_EN
- Defined: in DONE, in_ready = out_ready. When out_valid&&out_ready&&in_valid occur together, the new operands are latched and the FSM goes directly to RUN, skipping IDLE. Throughput becomes one op per NCHUNK+1 cycles.
- Undefined: in_ready is high only in IDLE, as above.

Decomposition:
- Package serial_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a localparam function computing NCHUNK and the counter width clog2(NCHUNK) (minimum 1);
  - an elaboration check that WIDTH % CHUNK == 0.
- One sub-module, chunk_adder: combinational CHUNK-bit ripple of full adders. Inputs are a, b and ci; outputs are s, co, and c_msb (carry into the top bit, used for overflow).

Test Plan (WIDTH=32, CHUNK=8):
1. Assert rst for 3 cycles, with rst also asserted mid-clock -> immediately in_ready=1, out_valid=0, sum=0, cout=0, overflow=0.
2. a=0xFFFFFFFF, b=1, cin=0, sub=0 -> out_valid exactly 4 cycles after accept; sum=0, cout=1, overflow=0. Then a=3, b=4, cin=1 -> sum=8, cout=0.
3. a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, overflow=1, cout=0.
4. a=5, b=7, sub=1, cin=1 (must be ignored) -> sum=0xFFFFFFFE, cout=0, overflow=0. Then a=7, b=5, sub=1 -> sum=2, cout=1.
5. Hold out_ready=0 for 10 cycles in DONE while toggling in_valid and operands -> sum, cout and overflow stay stable; in_ready=0 (or follows out_ready=0 with B2B); no new op is accepted. On release, exactly one result handshake occurs.
6. Reset pulse during RUN (counter=2) -> out_valid never rises for the aborted op. After release, a=0x12345678, b=0x11111111 -> sum=0x23456789. With SERIAL_ADDER_B2B_EN, a back-to-back pair completes with out_valid rising 5 cycles apart.
